// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit -- single-issue instruction fetch stage with an IF/ID register.
//
// The PC register drives the instruction memory address directly. The
// memory returns the instruction combinationally in the same cycle, and the
// block captures it into the IF/ID register on the next rising edge. That
// gives exactly one cycle of latency from imem_pc to the if_id_* outputs.
//
// Parameters
//   PC_WIDTH    : width of the program counter (must be >= 2)
//   INST_WIDTH  : width of an instruction word
//   RESET_PC    : first fetch address after reset
//
// Ports
//   clk            in   clock; all state updates on its rising edge
//   rst_n          in   asynchronous active-low reset
//   stall          in   downstream cannot accept; PC and IF/ID hold
//   redirect_valid in   taken branch/jump; load redirect_pc and flush IF/ID
//   redirect_pc    in   redirect target address
//   imem_pc        out  instruction memory address (straight from pc_q)
//   imem_inst      in   instruction for imem_pc, valid in the same cycle
//   if_id_valid    out  IF/ID holds a valid instruction
//   if_id_pc       out  PC of the captured instruction
//   if_id_inst     out  captured instruction
//   misalign_err   out  sticky: PC had bits [1:0] != 0; cleared by redirect
//   fsm_state      out  debug view of the FSM: 0=BOOT, 1=RUN, 2=FAULT
//
// Handshake: this stage has no valid/ready pair of its own. stall acts as
// "not ready" from downstream. When stall=1, nothing in the stage moves.
// if_id_valid qualifies if_id_pc/if_id_inst. redirect_valid is a
// single-cycle command. It is sampled on every edge and it overrides stall.
// ---------------------------------------------------------------------------
module fetch_unit #(
  parameter int unsigned                PC_WIDTH   = 32,
  parameter int unsigned                INST_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0]        RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  stall,
  input  logic                  redirect_valid,
  input  logic [PC_WIDTH-1:0]   redirect_pc,
  output logic [PC_WIDTH-1:0]   imem_pc,
  input  logic [INST_WIDTH-1:0] imem_inst,
  output logic                  if_id_valid,
  output logic [PC_WIDTH-1:0]   if_id_pc,
  output logic [INST_WIDTH-1:0] if_id_inst,
  output logic                  misalign_err,
  output logic [1:0]            fsm_state
);

  // -------------------------------------------------------------------------
  // State encoding
  // -------------------------------------------------------------------------
  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FAULT = 2'd2
  } state_t;

  // PC next-value selector
  typedef enum logic [1:0] {
    PC_HOLD  = 2'd0,
    PC_INC   = 2'd1,
    PC_REDIR = 2'd2
  } pc_sel_t;

  localparam logic [PC_WIDTH-1:0] PC_STEP = PC_WIDTH'(4);

  state_t                  state_q;
  state_t                  state_d;

  logic [PC_WIDTH-1:0]     pc_q;
  logic [PC_WIDTH-1:0]     pc_inc;
  logic                    pc_misaligned;

  // Control decoded from the FSM by the output process
  pc_sel_t                 pc_sel;
  logic                    capture;     // load IF/ID from the memory
  logic                    flush;       // force if_id_valid low
  logic                    err_set;
  logic                    err_clr;

  // -------------------------------------------------------------------------
  // Datapath helpers
  // -------------------------------------------------------------------------
  // Plain modulo-2^PC_WIDTH add: wrap-around is legal and raises no flag.
  assign pc_inc        = pc_q + PC_STEP;
  assign pc_misaligned = (pc_q[1:0] != 2'b00);

  // The memory address is the PC register, with no logic in the path.
  assign imem_pc   = pc_q;
  assign fsm_state = state_q;

  // -------------------------------------------------------------------------
  // FSM process 1: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_BOOT;
    end else begin
      state_q <= state_d;
    end
  end

  // -------------------------------------------------------------------------
  // FSM process 2: next-state logic
  // A redirect always lands in RUN. If the target is misaligned, the
  // alignment check in RUN sends the FSM to FAULT one edge later.
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_BOOT: begin
        state_d = ST_RUN;
      end
      ST_RUN: begin
        if (redirect_valid) begin
          state_d = ST_RUN;
        end else if (stall) begin
          state_d = ST_RUN;
        end else if (pc_misaligned) begin
          state_d = ST_FAULT;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_FAULT: begin
        if (redirect_valid) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_FAULT;
        end
      end
      default: begin
        state_d = ST_BOOT;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // FSM process 3: output / control decode
  // The priority order is: redirect, then stall, then the alignment check,
  // then a normal fetch. A misaligned PC never captures. This keeps
  // whatever the memory returns for that address (possibly undriven) out of
  // the IF/ID register.
  // -------------------------------------------------------------------------
  always_comb begin
    pc_sel  = PC_HOLD;
    capture = 1'b0;
    flush   = 1'b0;
    err_set = 1'b0;
    err_clr = 1'b0;
    case (state_q)
      ST_BOOT: begin
        // This cycle lets reset release settle. No capture happens, but a
        // redirect presented now is still taken.
        flush = 1'b1;
        if (redirect_valid) begin
          pc_sel  = PC_REDIR;
          err_clr = 1'b1;
        end
      end
      ST_RUN: begin
        if (redirect_valid) begin
          pc_sel  = PC_REDIR;
          flush   = 1'b1;
          err_clr = 1'b1;
        end else if (stall) begin
          pc_sel  = PC_HOLD;
        end else if (pc_misaligned) begin
          pc_sel  = PC_HOLD;
          flush   = 1'b1;
          err_set = 1'b1;
        end else begin
          pc_sel  = PC_INC;
          capture = 1'b1;
        end
      end
      ST_FAULT: begin
        if (redirect_valid) begin
          pc_sel  = PC_REDIR;
          flush   = 1'b1;
          err_clr = 1'b1;
        end else begin
          pc_sel  = PC_HOLD;
        end
      end
      default: begin
        pc_sel  = PC_HOLD;
        flush   = 1'b1;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // PC register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
    end else begin
      case (pc_sel)
        PC_INC:   pc_q <= pc_inc;
        PC_REDIR: pc_q <= redirect_pc;
        default:  pc_q <= pc_q;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // IF/ID register
  // pc and inst only change on a capture. A flush clears only the valid
  // bit, so the stale payload stays visible but is not qualified.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_id_valid <= 1'b0;
      if_id_pc    <= '0;
      if_id_inst  <= '0;
    end else begin
      if (capture) begin
        if_id_valid <= 1'b1;
        if_id_pc    <= pc_q;
        if_id_inst  <= imem_inst;
      end else if (flush) begin
        if_id_valid <= 1'b0;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Sticky misalignment flag
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      misalign_err <= 1'b0;
    end else begin
      if (err_clr) begin
        misalign_err <= 1'b0;
      end else if (err_set) begin
        misalign_err <= 1'b1;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Design invariants
  // -------------------------------------------------------------------------
  // A qualified instruction always comes from a word-aligned address.
  a_valid_aligned : assert property (@(posedge clk) disable iff (!rst_n)
    if_id_valid |-> (if_id_pc[1:0] == 2'b00));

  // In FAULT the flag is set and nothing is qualified.
  a_fault_outputs : assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == ST_FAULT) |-> (misalign_err && !if_id_valid));

  // The FSM never reaches the unused encoding.
  a_state_legal : assert property (@(posedge clk) disable iff (!rst_n)
    state_q != 2'd3);

endmodule

// File: tb/tb_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_unit -- self-checking bench for fetch_unit.
// Directed scenarios use hand-derived constants. A randomized run compares
// every cycle against a rule-level reference model.
// ---------------------------------------------------------------------------
module tb_fetch_unit;

  localparam int PCW = 32;
  localparam int IW  = 32;
  localparam logic [PCW-1:0] RST_PC = 32'h0000_0000;

  localparam logic [1:0] S_BOOT  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_FAULT = 2'd2;

  localparam logic [IW-1:0] W_A = 32'hA000_00A0;
  localparam logic [IW-1:0] W_B = 32'hB000_00B1;
  localparam logic [IW-1:0] W_C = 32'hC000_00C2;
  localparam logic [IW-1:0] W_D = 32'hD000_00D3;
  localparam logic [IW-1:0] POISON = 32'hBAD0_BAD0;

  // -------------------------------------------------------------------------
  // Clock / reset / DUT
  // -------------------------------------------------------------------------
  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           stall = 1'b0;
  logic           redirect_valid = 1'b0;
  logic [PCW-1:0] redirect_pc = '0;
  logic [PCW-1:0] imem_pc;
  logic [IW-1:0]  imem_inst;
  logic           if_id_valid;
  logic [PCW-1:0] if_id_pc;
  logic [IW-1:0]  if_id_inst;
  logic           misalign_err;
  logic [1:0]     fsm_state;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  fetch_unit #(.PC_WIDTH(PCW), .INST_WIDTH(IW), .RESET_PC(RST_PC)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_pc(imem_pc), .imem_inst(imem_inst),
    .if_id_valid(if_id_valid), .if_id_pc(if_id_pc), .if_id_inst(if_id_inst),
    .misalign_err(misalign_err), .fsm_state(fsm_state)
  );

  // Instruction memory: words 0..3 are A..D, and other words are derived
  // from the address. A misaligned address returns a poison pattern that
  // must never be captured.
  function automatic logic [IW-1:0] mem_word(input logic [PCW-1:0] a);
    logic [IW-1:0] tbl [4];
    tbl[0] = W_A; tbl[1] = W_B; tbl[2] = W_C; tbl[3] = W_D;
    if (a[1:0] != 2'b00) return POISON;
    if (a < 32'd16) return tbl[a[3:2]];
    return {a[15:0] ^ 16'h5A5A, a[31:16] ^ 16'h0F0F};
  endfunction

  assign imem_inst = mem_word(imem_pc);

  // -------------------------------------------------------------------------
  // Reference model (rule level)
  // -------------------------------------------------------------------------
  logic [PCW-1:0] m_pc;
  logic           m_valid;
  logic [PCW-1:0] m_ipc;
  logic [IW-1:0]  m_inst;
  logic           m_err;
  logic           m_boot;
  logic           m_fault;

  task automatic model_reset();
    m_pc = RST_PC; m_valid = 1'b0; m_ipc = '0; m_inst = '0;
    m_err = 1'b0; m_boot = 1'b1; m_fault = 1'b0;
  endtask

  task automatic model_edge(input logic s, input logic rv, input logic [PCW-1:0] rpc);
    if (m_boot) begin
      m_boot = 1'b0;
      m_valid = 1'b0;
      if (rv) begin m_pc = rpc; m_err = 1'b0; end
    end else if (rv) begin
      m_pc = rpc; m_valid = 1'b0; m_err = 1'b0; m_fault = 1'b0;
    end else if (s || m_fault) begin
      // nothing moves
    end else if (m_pc % 4 != 0) begin
      m_valid = 1'b0; m_err = 1'b1; m_fault = 1'b1;
    end else begin
      m_ipc = m_pc; m_inst = mem_word(m_pc); m_valid = 1'b1; m_pc = m_pc + 4;
    end
  endtask

  function automatic logic [1:0] model_state();
    if (m_boot) return S_BOOT;
    if (m_fault) return S_FAULT;
    return S_RUN;
  endfunction

  // -------------------------------------------------------------------------
  // Drivers (all called at posedge+1; each step returns at posedge+1)
  // -------------------------------------------------------------------------
  task automatic step(input logic s, input logic rv, input logic [PCW-1:0] rpc);
    stall = s; redirect_valid = rv; redirect_pc = rpc;
    @(posedge clk);
    model_edge(s, rv, rpc);
    #1;
    stall = 1'b0; redirect_valid = 1'b0;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // -------------------------------------------------------------------------
  // Tests
  // -------------------------------------------------------------------------
  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    vectors++;
    if (imem_pc !== RST_PC) begin miscompares++; $display("FAIL reset_pc: got %h want %h", imem_pc, RST_PC); end
    vectors++;
    if ({if_id_valid, if_id_pc, if_id_inst, misalign_err} !== '0) begin
      miscompares++; $display("FAIL reset_ifid: got v=%b pc=%h inst=%h err=%b want zeros",
                               if_id_valid, if_id_pc, if_id_inst, misalign_err);
    end
    vectors++;
    if (fsm_state !== S_BOOT) begin miscompares++; $display("FAIL reset_state: got %0d want %0d", fsm_state, S_BOOT); end
    apply_reset();
    step(1'b0, 1'b0, '0);  // BOOT edge: no capture
    vectors++;
    if (if_id_valid !== 1'b0 || imem_pc !== RST_PC || fsm_state !== S_RUN) begin
      miscompares++; $display("FAIL boot_cycle: got v=%b pc=%h st=%0d want v=0 pc=%h st=1",
                               if_id_valid, imem_pc, fsm_state, RST_PC);
    end
  endtask

  task automatic test_sequential();
    logic [IW-1:0] exp_inst [4];
    exp_inst[0] = W_A; exp_inst[1] = W_B; exp_inst[2] = W_C; exp_inst[3] = W_D;
    apply_reset();
    step(1'b0, 1'b0, '0);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, '0);
      vectors++;
      if (if_id_valid !== 1'b1 || if_id_pc !== 32'(4*i) || if_id_inst !== exp_inst[i]) begin
        miscompares++; $display("FAIL seq_fetch[%0d]: got v=%b pc=%h inst=%h want v=1 pc=%h inst=%h",
                                 i, if_id_valid, if_id_pc, if_id_inst, 32'(4*i), exp_inst[i]);
      end
    end
  endtask

  task automatic test_stall();
    apply_reset();
    repeat (3) step(1'b0, 1'b0, '0);   // now if_id_pc=4, imem_pc=8
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, '0);
      vectors++;
      if (if_id_pc !== 32'd4 || if_id_inst !== W_B || imem_pc !== 32'd8 || if_id_valid !== 1'b1) begin
        miscompares++; $display("FAIL stall_hold[%0d]: got ipc=%h inst=%h pc=%h v=%b want 4/%h/8/1",
                                 i, if_id_pc, if_id_inst, imem_pc, if_id_valid, W_B);
      end
    end
    step(1'b0, 1'b0, '0);
    vectors++;
    if (if_id_pc !== 32'd8 || if_id_inst !== W_C) begin
      miscompares++; $display("FAIL stall_release: got ipc=%h inst=%h want 8/%h", if_id_pc, if_id_inst, W_C);
    end
  endtask

  task automatic test_redirect_stall();
    apply_reset();
    repeat (3) step(1'b0, 1'b0, '0);   // imem_pc=8
    step(1'b1, 1'b1, 32'h40);
    vectors++;
    if (imem_pc !== 32'h40 || if_id_valid !== 1'b0) begin
      miscompares++; $display("FAIL redir_stall: got pc=%h v=%b want 40/0", imem_pc, if_id_valid);
    end
    step(1'b0, 1'b0, '0);
    vectors++;
    if (if_id_pc !== 32'h40 || if_id_valid !== 1'b1 || if_id_inst !== mem_word(32'h40)) begin
      miscompares++; $display("FAIL redir_capture: got ipc=%h v=%b inst=%h want 40/1/%h",
                               if_id_pc, if_id_valid, if_id_inst, mem_word(32'h40));
    end
  endtask

  task automatic test_misalign();
    apply_reset();
    repeat (2) step(1'b0, 1'b0, '0);
    step(1'b0, 1'b1, 32'h22);
    vectors++;
    if (imem_pc !== 32'h22 || misalign_err !== 1'b0 || if_id_valid !== 1'b0) begin
      miscompares++; $display("FAIL mis_redirect: got pc=%h err=%b v=%b want 22/0/0", imem_pc, misalign_err, if_id_valid);
    end
    step(1'b0, 1'b0, '0);
    vectors++;
    if (misalign_err !== 1'b1 || fsm_state !== S_FAULT) begin
      miscompares++; $display("FAIL mis_enter: got err=%b st=%0d want 1/2", misalign_err, fsm_state);
    end
    for (int i = 0; i < 5; i++) begin
      step(1'($urandom_range(0, 1)), 1'b0, '0);
      vectors++;
      if (imem_pc !== 32'h22 || if_id_valid !== 1'b0 || misalign_err !== 1'b1 || fsm_state !== S_FAULT) begin
        miscompares++; $display("FAIL mis_hold[%0d]: got pc=%h v=%b err=%b st=%0d want 22/0/1/2",
                                 i, imem_pc, if_id_valid, misalign_err, fsm_state);
      end
    end
    step(1'b0, 1'b1, 32'h24);
    vectors++;
    if (misalign_err !== 1'b0 || imem_pc !== 32'h24 || fsm_state !== S_RUN) begin
      miscompares++; $display("FAIL mis_clear: got err=%b pc=%h st=%0d want 0/24/1", misalign_err, imem_pc, fsm_state);
    end
    step(1'b0, 1'b0, '0);
    vectors++;
    if (if_id_pc !== 32'h24 || if_id_valid !== 1'b1) begin
      miscompares++; $display("FAIL mis_recover: got ipc=%h v=%b want 24/1", if_id_pc, if_id_valid);
    end
  endtask

  task automatic test_wrap();
    apply_reset();
    repeat (2) step(1'b0, 1'b0, '0);
    step(1'b0, 1'b1, 32'hFFFF_FFFC);
    step(1'b0, 1'b0, '0);
    vectors++;
    if (if_id_pc !== 32'hFFFF_FFFC || if_id_valid !== 1'b1 || imem_pc !== 32'h0) begin
      miscompares++; $display("FAIL wrap_top: got ipc=%h v=%b pc=%h want FFFFFFFC/1/0", if_id_pc, if_id_valid, imem_pc);
    end
    step(1'b0, 1'b0, '0);
    vectors++;
    if (if_id_pc !== 32'h0 || if_id_inst !== W_A || misalign_err !== 1'b0) begin
      miscompares++; $display("FAIL wrap_zero: got ipc=%h inst=%h err=%b want 0/%h/0", if_id_pc, if_id_inst, misalign_err, W_A);
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    repeat (4) step(1'b0, 1'b0, '0);
    // Assert reset between edges with a redirect and stall pending.
    stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h80;
    #1;
    rst_n = 1'b0;
    model_reset();
    #1;
    vectors++;
    if (imem_pc !== RST_PC || if_id_valid !== 1'b0 || if_id_pc !== '0 || if_id_inst !== '0 ||
        misalign_err !== 1'b0 || fsm_state !== S_BOOT) begin
      miscompares++; $display("FAIL async_reset: got pc=%h v=%b ipc=%h inst=%h err=%b st=%0d want cleared",
                               imem_pc, if_id_valid, if_id_pc, if_id_inst, misalign_err, fsm_state);
    end
    stall = 1'b0; redirect_valid = 1'b0;
    #1;
    rst_n = 1'b1;
    @(posedge clk); model_edge(1'b0, 1'b0, '0); #1;
    step(1'b0, 1'b0, '0);
    vectors++;
    if (if_id_pc !== 32'h0 || if_id_inst !== W_A || if_id_valid !== 1'b1) begin
      miscompares++; $display("FAIL async_resume: got ipc=%h inst=%h v=%b want 0/%h/1", if_id_pc, if_id_inst, if_id_valid, W_A);
    end
  endtask

  task automatic test_random();
    logic           s, rv;
    logic [PCW-1:0] rpc;
    apply_reset();
    for (int i = 0; i < 400; i++) begin
      s   = ($urandom_range(0, 99) < 30);
      rv  = ($urandom_range(0, 99) < 12);
      rpc = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
      if ($urandom_range(0, 3) == 0) rpc[1:0] = 2'($urandom_range(1, 3));
      step(s, rv, rpc);
      vectors++;
      if (imem_pc !== m_pc || if_id_valid !== m_valid || if_id_pc !== m_ipc || if_id_inst !== m_inst ||
          misalign_err !== m_err || fsm_state !== model_state()) begin
        miscompares++;
        $display("FAIL rand[%0d]: got pc=%h v=%b ipc=%h inst=%h err=%b st=%0d want pc=%h v=%b ipc=%h inst=%h err=%b st=%0d",
                 i, imem_pc, if_id_valid, if_id_pc, if_id_inst, misalign_err, fsm_state,
                 m_pc, m_valid, m_ipc, m_inst, m_err, model_state());
      end
    end
  endtask

  // -------------------------------------------------------------------------
  // Sequence and report
  // -------------------------------------------------------------------------
  initial begin
    #2;
    test_reset();
    test_sequential();
    test_stall();
    test_redirect_stall();
    test_misalign();
    test_wrap();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
